demux_stream_1ton: RTL and testbench

DEMUX_STREAM_1TON -- requirements
Module: demux_stream_1toN

---
 rtl/demux_stream_1ton_if.sv | 31 +++
 rtl/demux_stream_1ton.sv | 73 +++++++
 tb/tb_demux_stream_1ton.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/demux_stream_1ton_if.sv
// Stream bus for the 1-to-N demux: one upstream word channel fanning out to N_CH
// downstream channels that share a single payload bus.
interface demux_stream_1ton_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 32,
  parameter int SEL_W  = 5
);
  // Handshakes are strict valid/ready: a word moves on a rising edge where valid
  // and ready are both 1. Ready never looks at valid. A valid word and its
  // payload stay put until they are accepted.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_bcast;
  logic [N_CH-1:0]   out_valid;
  logic [N_CH-1:0]   out_ready;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        err_cnt;
  logic              busy;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data, err_cnt, busy
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data, err_cnt, busy
  );
endinterface

// File: rtl/demux_stream_1ton.sv
// One-stage 1-to-N stream demux with unicast/broadcast routing, per-channel
// delivery tracking and a saturating count of words dropped for a bad selector.
module demux_stream_1ton #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 32,
  parameter int SEL_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_stream_1ton_if.slave   bus,
  output logic                 dbg_state
);
  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [N_CH-1:0] ONE   = {{(N_CH-1){1'b0}}, 1'b1};
  localparam logic [SEL_W:0]  N_LIM = (SEL_W+1)'(N_CH);

  state_t            state_q, state_d;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        err_q, err_d;
  logic [N_CH-1:0]   remain;
  logic              free, take, in_range, load, drop;

  // Channels still waiting after this cycle's deliveries. The stage can take a
  // new word as soon as nothing would remain.
  assign remain   = pend_q & ~bus.out_ready;
  assign free     = !rst && (remain == '0);
  assign take     = bus.in_valid && free;
  assign in_range = {1'b0, bus.in_sel} < N_LIM;
  assign load     = take && (bus.in_bcast || in_range);
  assign drop     = take && !bus.in_bcast && !in_range;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      pend_q  <= '0;
      data_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = remain;
    data_d  = data_q;
    err_d   = err_q;
    if (load) begin
      pend_d = bus.in_bcast ? {N_CH{1'b1}} : (ONE << bus.in_sel);
      data_d = bus.in_data;
    end
    if (drop && err_q != 8'hFF) err_d = err_q + 8'd1;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_HOLD;
      ST_HOLD:  if (!load && remain == '0) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    bus.in_ready  = free;
    bus.out_valid = pend_q;
    bus.out_data  = data_q;
    bus.err_cnt   = err_q;
    bus.busy      = |pend_q;
    dbg_state     = state_q;
  end
endmodule

// File: tb/tb_demux_stream_1ton.sv
// Directed bench for demux_stream_1ton: a 32-channel instance and a 24-channel
// instance (for out-of-range selectors) sharing clock and reset.
module tb_demux_stream_1ton;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_a, dbg_b;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  demux_stream_1ton_if #(.DATA_W(8), .N_CH(32), .SEL_W(5)) a ();
  demux_stream_1ton_if #(.DATA_W(8), .N_CH(24), .SEL_W(5)) b ();

  demux_stream_1ton #(.DATA_W(8), .N_CH(32), .SEL_W(5)) dut_a (
    .clk(clk), .rst(rst), .bus(a.slave), .dbg_state(dbg_a));
  demux_stream_1ton #(.DATA_W(8), .N_CH(24), .SEL_W(5)) dut_b (
    .clk(clk), .rst(rst), .bus(b.slave), .dbg_state(dbg_b));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    a.in_valid = 0; a.in_data = '0; a.in_sel = '0; a.in_bcast = 0; a.out_ready = '0;
    b.in_valid = 0; b.in_data = '0; b.in_sel = '0; b.in_bcast = 0; b.out_ready = '0;
    step(); step();

    // reset state
    check("rst_out_valid", a.out_valid, 0);
    check("rst_busy", a.busy, 0);
    check("rst_out_data", a.out_data, 0);
    check("rst_err_cnt", a.err_cnt, 0);
    check("rst_in_ready", a.in_ready, 0);
    check("rst_state", dbg_a, 0);
    rst = 0;
    #1;
    check("first_in_ready", a.in_ready, 1);

    // unicast to channel 7
    a.out_ready = '1;
    a.in_valid = 1; a.in_data = 8'hA5; a.in_sel = 5'd7; a.in_bcast = 0;
    step();
    a.in_valid = 0;
    check("uni_out_valid", a.out_valid, 64'h80);
    check("uni_out_data", a.out_data, 8'hA5);
    check("uni_busy", a.busy, 1);
    check("uni_state", dbg_a, 1);
    step();
    check("uni_drain_valid", a.out_valid, 0);
    check("uni_drain_busy", a.busy, 0);
    check("uni_drain_state", dbg_a, 0);

    // broadcast with staggered ready
    a.out_ready = 32'h0000FFFF;
    a.in_valid = 1; a.in_data = 8'h3C; a.in_bcast = 1;
    #1;
    check("bc_in_ready_empty", a.in_ready, 1);
    step();
    a.in_valid = 0; a.in_bcast = 0;
    check("bc_out_valid_all", a.out_valid, 64'hFFFFFFFF);
    check("bc_in_ready_part", a.in_ready, 0);
    check("bc_out_data", a.out_data, 8'h3C);
    step();
    a.out_ready = 32'hFFFF0000;
    #1;
    check("bc_out_valid_upper", a.out_valid, 64'hFFFF0000);
    check("bc_in_ready_last", a.in_ready, 1);
    check("bc_out_data_held", a.out_data, 8'h3C);
    step();
    check("bc_done_valid", a.out_valid, 0);
    check("bc_done_busy", a.busy, 0);

    // full throughput, selector 0..31
    a.out_ready = '1;
    a.in_valid = 1;
    for (int i = 0; i < 32; i++) begin
      a.in_sel = 5'(i);
      a.in_data = 8'(8'h40 + i);
      #1;
      check("tp_in_ready", a.in_ready, 1);
      step();
      check("tp_out_valid", a.out_valid, 64'd1 << i);
      check("tp_out_data", a.out_data, 64'(8'h40 + i));
    end
    a.in_valid = 0;
    step();
    check("tp_drain", a.out_valid, 0);

    // out-of-range selectors on the 24-channel instance
    b.out_ready = '1;
    b.in_valid = 1; b.in_sel = 5'd30; b.in_data = 8'h11;
    #1;
    check("oor_ready_30", b.in_ready, 1);
    step();
    b.in_sel = 5'd31; b.in_data = 8'h22;
    check("oor_valid_30", b.out_valid, 0);
    check("oor_ready_31", b.in_ready, 1);
    step();
    b.in_valid = 0;
    check("oor_valid_31", b.out_valid, 0);
    check("oor_err_2", b.err_cnt, 2);
    check("oor_data_kept", b.out_data, 0);
    check("oor_busy", b.busy, 0);
    b.in_valid = 1; b.in_sel = 5'd24;
    for (int i = 0; i < 253; i++) step();
    check("oor_err_255", b.err_cnt, 255);
    for (int i = 0; i < 47; i++) step();
    check("oor_err_sat", b.err_cnt, 255);
    b.in_sel = 5'd23; b.in_data = 8'h99;
    step();
    b.in_valid = 0;
    check("edge_ch23_valid", b.out_valid, 64'h800000);
    check("edge_ch23_data", b.out_data, 8'h99);
    check("edge_ch23_err", b.err_cnt, 255);
    step();
    check("edge_ch23_drain", b.out_valid, 0);

    // broadcast stalled 3 cycles, blocked upstream word, then reset
    a.out_ready = '0;
    a.in_valid = 1; a.in_bcast = 1; a.in_data = 8'h5A;
    step();
    a.in_bcast = 0; a.in_sel = 5'd3; a.in_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", a.out_valid, 64'hFFFFFFFF);
      check("stall_in_ready", a.in_ready, 0);
      check("stall_data", a.out_data, 8'h5A);
      step();
    end
    a.in_valid = 0;
    rst = 1; a.out_ready = '1;
    #1;
    check("rst_in_ready_held", a.in_ready, 0);
    step();
    rst = 0;
    check("rst_mid_valid", a.out_valid, 0);
    check("rst_mid_busy", a.busy, 0);
    check("rst_mid_err", a.err_cnt, 0);
    check("rst_mid_data", a.out_data, 0);
    check("rst_b_err", b.err_cnt, 0);
    a.in_valid = 1; a.in_sel = 5'd0; a.in_data = 8'hC3;
    step();
    a.in_valid = 0;
    check("post_rst_valid", a.out_valid, 64'h1);
    check("post_rst_data", a.out_data, 8'hC3);
    step();
    check("post_rst_drain", a.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
